// File: rtl/md_sequencer_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
package md_sequencer_pkg;

    // Default operand/result width; the iteration count equals the width.
    localparam int MD_XLEN = 32;
    localparam int MD_ITER = MD_XLEN;

    // funct3 encodings of the M extension.
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL     = 3'd1,
        ST_DIV     = 3'd2,
        ST_SPECIAL = 3'd3,
        ST_FIX     = 3'd4,
        ST_DONE    = 3'd5
    } md_state_e;

    // Any of the four divide/remainder ops.
    function automatic logic op_is_div(input md_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    // Remainder ops return the partial remainder instead of the quotient.
    function automatic logic op_is_rem(input md_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    // Ops that return the upper half of the product.
    function automatic logic op_is_mul_hi(input md_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    // rs1 is interpreted as signed. Plain MUL is treated as unsigned since
    // the low product word does not depend on operand signedness.
    function automatic logic rs1_is_signed(input md_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is interpreted as signed.
    function automatic logic rs2_is_signed(input md_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Request/response bundle between the EXE stage and the multiply/divide unit.
interface md_sequencer_if #(
    parameter int XLEN = 32
);

    logic            start_i;   // valid M-op in EXE this cycle
    logic [2:0]      op_i;      // funct3
    logic [XLEN-1:0] rs1_i;     // forwarded operand 1
    logic [XLEN-1:0] rs2_i;     // forwarded operand 2
    logic            flush_i;   // kill the current op
    logic            busy_o;    // hold the pipeline
    logic            done_o;    // one-cycle result-valid pulse
    logic [XLEN-1:0] result_o;  // result, held until the next op completes

    // EXE-stage side: issues ops and consumes the result.
    modport master (
        output start_i, op_i, rs1_i, rs2_i, flush_i,
        input  busy_o, done_o, result_o
    );

    // Unit side.
    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, flush_i,
        output busy_o, done_o, result_o
    );

endinterface

// File: rtl/md_sequencer.sv
// Iterative RV32M multiply/divide unit. One shift/add datapath is shared by
// MUL* (shift-add, 1 bit per cycle) and DIV*/REM* (restoring, 1 bit per cycle).
// acc_hi:acc_lo is the working register pair:
//   MUL: acc_hi = running high product, acc_lo = multiplier shifting out right
//   DIV: acc_hi = partial remainder,    acc_lo = dividend out / quotient in
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int XLEN         = MD_XLEN,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    md_sequencer_if.slave md
);

    localparam int              CNT_W     = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        state, next_state;
    md_op_e           op_q;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  acc_hi, acc_lo, op_b;
    logic             neg_res, neg_rem;
    logic             done_q;
    logic [XLEN-1:0]  result_q;

    // Accept-cycle decode
    md_op_e          op_in;
    logic            accept, busy;
    logic            sign1, sign2, div_zero, div_ovf, special_in;
    logic [XLEN-1:0] mag1, mag2, special_val;

    // Shared iteration adder
    logic            add_sub, no_borrow;
    logic [XLEN:0]   add_a, add_b, add_b_eff;
    logic [XLEN+1:0] add_sum;
    logic [XLEN-1:0] iter_hi, iter_lo;

    // Sign correction / result select
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    // Decode the incoming op: operand magnitudes, signs and the RISC-V
    // special cases that bypass the iteration when FAST_SPECIAL is set.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no latch can be inferred.
        op_in       = md_op_e'(md.op_i);
        sign1       = md.rs1_i[XLEN-1] & rs1_is_signed(op_in);
        sign2       = md.rs2_i[XLEN-1] & rs2_is_signed(op_in);
        mag1        = sign1 ? -md.rs1_i : md.rs1_i;
        mag2        = sign2 ? -md.rs2_i : md.rs2_i;
        div_zero    = (md.rs2_i == '0);
        div_ovf     = (op_in == OP_DIV || op_in == OP_REM) &&
                      (md.rs1_i == INT_MIN) && (md.rs2_i == '1);
        special_in  = FAST_SPECIAL && op_is_div(op_in) && (div_zero || div_ovf);
        special_val = md.rs1_i;
        if (div_zero) begin
            special_val = op_is_rem(op_in) ? md.rs1_i : '1;
        end else if (div_ovf) begin
            special_val = op_is_rem(op_in) ? '0 : md.rs1_i;
        end
    end

    // Next-state logic and the combinational pipeline hold.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        busy       = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                accept = md.start_i & ~md.flush_i;
                busy   = accept;
                if (accept) begin
                    if (!op_is_div(op_in)) begin
                        next_state = ST_MUL;
                    end else if (special_in) begin
                        next_state = ST_SPECIAL;
                    end else begin
                        next_state = ST_DIV;
                    end
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                busy = 1'b1;
                if (md.flush_i) begin
                    next_state = ST_IDLE;
                end else if (cnt == LAST_ITER) begin
                    next_state = ST_FIX;
                end
            end
            ST_SPECIAL, ST_FIX: begin
                busy       = 1'b1;
                next_state = md.flush_i ? ST_IDLE : ST_DONE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // One iteration of the shared datapath. MUL adds the multiplicand into the
    // high word when the multiplier LSB is set, then shifts the pair right.
    // DIV shifts the next dividend bit into the remainder and subtracts the
    // divisor; the adder carry-out doubles as the "remainder >= divisor" flag.
    always_comb begin
        add_sub = (state == ST_DIV);
        if (add_sub) begin
            add_a = {acc_hi, acc_lo[XLEN-1]};
            add_b = {1'b0, op_b};
        end else begin
            add_a = {1'b0, acc_hi};
            add_b = acc_lo[0] ? {1'b0, op_b} : '0;
        end
        add_b_eff = add_sub ? ~add_b : add_b;
        add_sum   = {1'b0, add_a} + {1'b0, add_b_eff} + {{(XLEN+1){1'b0}}, add_sub};
        no_borrow = add_sum[XLEN+1];
        if (add_sub) begin
            iter_hi = no_borrow ? add_sum[XLEN-1:0] : add_a[XLEN-1:0];
            iter_lo = {acc_lo[XLEN-2:0], no_borrow};
        end else begin
            iter_hi = add_sum[XLEN:1];
            iter_lo = {add_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    // Sign-correct the magnitude result and pick the word the op returns.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -acc_lo : acc_lo;
        rem_fix  = neg_rem ? -acc_hi : acc_hi;
        if (op_q == OP_MUL) begin
            fix_result = prod_fix[XLEN-1:0];
        end else if (op_is_mul_hi(op_q)) begin
            fix_result = prod_fix[2*XLEN-1:XLEN];
        end else if (op_is_rem(op_q)) begin
            fix_result = rem_fix;
        end else begin
            fix_result = quo_fix;
        end
    end

    // Operand capture at accept and per-cycle iteration of the working pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_MUL;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            op_b    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (accept) begin
            op_q    <= op_in;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= special_in ? special_val : mag1;
            op_b    <= mag2;
            // A zero divisor must yield all-ones regardless of the dividend
            // sign, so the quotient is never negated in that case.
            neg_res <= (sign1 ^ sign2) & ~div_zero;
            neg_rem <= sign1;
        end else if (state == ST_MUL || state == ST_DIV) begin
            acc_hi <= iter_hi;
            acc_lo <= iter_lo;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Registered completion pulse and result; the result holds between ops
    // and is untouched by a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= (next_state == ST_DONE);
            if (next_state == ST_DONE) begin
                result_q <= (state == ST_SPECIAL) ? acc_lo : fix_result;
            end
        end
    end

    assign md.busy_o   = busy;
    assign md.done_o   = done_q;
    assign md.result_o = result_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer: expected results are pushed
// to a scoreboard queue when an op is issued and popped when done_o fires.
module tb_md_sequencer;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb[$];
    logic [31:0] last_result;

    md_sequencer_if #(.XLEN(32)) bus ();

    md_sequencer #(
        .XLEN        (32),
        .FAST_SPECIAL(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .md   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural RV32M result, written directly from the ISA definition.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa, sb_, ub_s;
        logic [63:0]        ua, ub, p;
        logic               ovf;
        sa   = {{32{a[31]}}, a};
        sb_  = {{32{b[31]}}, b};
        ua   = {32'h0, a};
        ub   = {32'h0, b};
        ub_s = {32'h0, b};
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p    = '0;
        case (op)
            3'd0: begin p = ua * ub;   return p[31:0];  end
            3'd1: begin p = sa * sb_;  return p[63:32]; end
            3'd2: begin p = sa * ub_s; return p[63:32]; end
            3'd3: begin p = ua * ub;   return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called just after a rising edge; that cycle is the start cycle (cycle 0).
    // Returns in the done cycle, so a following call issues back-to-back.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string tag);
        int n;
        int busy_bad;
        logic got;
        logic [31:0] want;
        sb.push_back(exp);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        #1;
        check({tag, " busy@start"}, 32'(bus.busy_o), 32'd1);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.rs1_i   = $urandom;
        bus.rs2_i   = $urandom;
        n        = 1;
        busy_bad = 0;
        got      = 1'b0;
        while (n <= 80 && !got) begin
            if (bus.done_o) begin
                got = 1'b1;
            end else begin
                if (!bus.busy_o) busy_bad++;
                @(posedge clk);
                #1;
                n++;
            end
        end
        check({tag, " busy-gap"}, 32'(busy_bad), 32'd0);
        check({tag, " latency"}, 32'(n), 32'(lat));
        want = sb.pop_front();
        check({tag, " result"}, bus.result_o, want);
        check({tag, " busy@done"}, 32'(bus.busy_o), 32'd0);
        last_result = want;
    endtask

    // Quiet cycles: no pulse, no hold, result held.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle done", 32'(bus.done_o), 32'd0);
            check("idle busy", 32'(bus.busy_o), 32'd0);
            check("idle result", bus.result_o, last_result);
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          rlat;
        logic        seen_done;

        bus.start_i = 1'b0;
        bus.op_i    = 3'd0;
        bus.rs1_i   = '0;
        bus.rs2_i   = '0;
        bus.flush_i = 1'b0;
        last_result = '0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset done", 32'(bus.done_o), 32'd0);
        check("reset result", bus.result_o, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Multiply family
        run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "MUL 7*-3");          idle(1);
        run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, "MULH");              idle(1);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "MULHSU");            idle(1);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 34, "MULHU");             idle(1);

        // Divide family
        run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, "DIV -7/2");          idle(1);
        run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, "REM -7/2");          idle(1);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, "DIVU 100/7");                             idle(1);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 34, "REMU 100/7");                              idle(1);

        // Special cases on the short path
        run_op(3'd5, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 2, "DIVU x/0");                   idle(1);
        run_op(3'd6, 32'd5, 32'h0, 32'd5, 2, "REM 5/0");                                    idle(1);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "DIV ovf");            idle(1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, "REM ovf");            idle(1);
        run_op(3'd4, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 2, "DIV neg/0");                  idle(1);

        // Back-to-back: each start lands in the previous op's done cycle
        run_op(3'd3, 32'hDEAD_BEEF, 32'h0000_1000, 32'h0000_0DEA, 34, "b2b MULHU");
        run_op(3'd4, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C, 34, "b2b DIV");
        run_op(3'd7, 32'd9, 32'h0, 32'd9, 2, "b2b REMU/0");
        idle(1);

        // flush with start in IDLE: flush wins
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = 3'd0;
        bus.rs1_i   = 32'd3;
        bus.rs2_i   = 32'd3;
        #1;
        check("idle flush busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        check("idle flush not accepted", 32'(bus.busy_o), 32'd0);
        idle(1);

        // flush in cycle 10 of a DIV; new MUL accepted in cycle 11
        bus.start_i = 1'b1;
        bus.op_i    = 3'd4;
        bus.rs1_i   = 32'd77;
        bus.rs2_i   = 32'd5;
        seen_done   = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
            if (bus.done_o) seen_done = 1'b1;
            if (c == 10) bus.flush_i = 1'b1;
        end
        check("flush busy@10", 32'(bus.busy_o), 32'd1);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        if (bus.done_o) seen_done = 1'b1;
        check("flush no done", 32'(seen_done), 32'd0);
        check("flush idle@11", 32'(bus.busy_o), 32'd0);
        check("flush result kept", bus.result_o, last_result);
        run_op(3'd0, 32'd12345, 32'd678, 32'd8_369_910, 34, "MUL after flush");
        idle(1);

        // Randomised ops against the reference model
        for (int i = 0; i < 6; i++) begin
            rop  = 3'($urandom_range(0, 7));
            ra   = $urandom;
            rb   = $urandom;
            rlat = (rop >= 3'd4 && (rb == 0 || ((rop == 3'd4 || rop == 3'd6) &&
                    ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))) ? 2 : 34;
            run_op(rop, ra, rb, ref_md(rop, ra, rb), rlat, "random");
            idle(1);
        end

        // Asynchronous reset in the middle of a MUL
        bus.start_i = 1'b1;
        bus.op_i    = 3'd0;
        bus.rs1_i   = 32'd11;
        bus.rs2_i   = 32'd13;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre-reset busy", 32'(bus.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset busy", 32'(bus.busy_o), 32'd0);
        check("async reset done", 32'(bus.done_o), 32'd0);
        check("async reset result", bus.result_o, 32'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        last_result = '0;
        idle(2);
        run_op(3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 34, "DIVU after reset");
        idle(1);

        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
